// File: rtl/sine_arbiter.sv
// Round-robin front end that shares one Sine CORDIC core among NUM_REQ requesters.
// A watchdog turns a core that never signals done into an error response.
module sine_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ANGLE_W     = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         Clk_i,
  input  logic                         Rst_i,
  input  logic [NUM_REQ-1:0]           Req_i,
  input  logic [NUM_REQ*ANGLE_W-1:0]   Angle_i,
  output logic [NUM_REQ-1:0]           Gnt_o,
  output logic [NUM_REQ-1:0]           Valid_o,
  output logic [ANGLE_W-1:0]           Sine_o,
  output logic                         Err_o,
  output logic                         Busy_o,
  output logic                         Core_Start_o,
  output logic [ANGLE_W-1:0]           Core_Angle_o,
  input  logic [ANGLE_W-1:0]           Core_Sine_i,
  input  logic                         Core_Done_i
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_prev_q;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] valid_q, valid_d;
  logic [ANGLE_W-1:0] sine_q, sine_d;
  logic [ANGLE_W-1:0] core_angle_q, core_angle_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               core_start_q, core_start_d;

  logic               found;
  logic [ID_W-1:0]    win_id;
  logic [ANGLE_W-1:0] win_angle;
  logic               done_rise;

  // Search starts just after the last winner, so the one just served ranks lowest.
  always_comb begin
    found     = 1'b0;
    win_id    = '0;
    win_angle = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && Req_i[k] && (((int'(last_q) + i) % NUM_REQ) == k)) begin
          found     = 1'b1;
          win_id    = ID_W'(k);
          win_angle = Angle_i[k*ANGLE_W +: ANGLE_W];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    valid_d      = '0;
    sine_d       = sine_q;
    err_d        = err_q;
    core_start_d = 1'b0;
    core_angle_d = core_angle_q;
    done_rise    = Core_Done_i & ~done_prev_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = START;
          id_d           = win_id;
          last_d         = win_id;
          core_angle_d   = win_angle;
          gnt_d[win_id]  = 1'b1;
          core_start_d   = 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A done rise in the expiry cycle still delivers the real result.
        if (done_rise) begin
          sine_d        = Core_Sine_i;
          err_d         = 1'b0;
          valid_d[id_q] = 1'b1;
          state_d       = RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          sine_d        = '0;
          err_d         = 1'b1;
          valid_d[id_q] = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        sine_d  = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      done_prev_q  <= 1'b0;
      gnt_q        <= '0;
      valid_q      <= '0;
      sine_q       <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_angle_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      done_prev_q  <= Core_Done_i;
      gnt_q        <= gnt_d;
      valid_q      <= valid_d;
      sine_q       <= sine_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      core_angle_q <= core_angle_d;
    end
  end

  assign Gnt_o        = gnt_q;
  assign Valid_o      = valid_q;
  assign Sine_o       = sine_q;
  assign Err_o        = err_q;
  assign Busy_o       = busy_q;
  assign Core_Start_o = core_start_q;
  assign Core_Angle_o = core_angle_q;

endmodule

// File: tb/tb_sine_arbiter.sv
// Directed bench for sine_arbiter with a behavioural core that answers ~angle
// after a fixed latency (pulse done, held done, or never done).
module tb_sine_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ANGLE_W     = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int CORE_LAT    = 20;

  logic                       Clk_i = 1'b0;
  logic                       Rst_i;
  logic [NUM_REQ-1:0]         Req_i;
  logic [NUM_REQ*ANGLE_W-1:0] Angle_i;
  logic [NUM_REQ-1:0]         Gnt_o;
  logic [NUM_REQ-1:0]         Valid_o;
  logic [ANGLE_W-1:0]         Sine_o;
  logic                       Err_o;
  logic                       Busy_o;
  logic                       Core_Start_o;
  logic [ANGLE_W-1:0]         Core_Angle_o;

  int                         core_mode = 0;
  logic                       core_busy = 1'b0;
  int                         core_cnt = 0;
  logic                       core_done = 1'b0;
  logic [ANGLE_W-1:0]         core_sine = '0;
  logic [ANGLE_W-1:0]         core_lat_angle = '0;

  int n_cmp = 0;
  int n_bad = 0;

  sine_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ANGLE_W(ANGLE_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk_i(Clk_i),
    .Rst_i(Rst_i),
    .Req_i(Req_i),
    .Angle_i(Angle_i),
    .Gnt_o(Gnt_o),
    .Valid_o(Valid_o),
    .Sine_o(Sine_o),
    .Err_o(Err_o),
    .Busy_o(Busy_o),
    .Core_Start_o(Core_Start_o),
    .Core_Angle_o(Core_Angle_o),
    .Core_Sine_i(core_sine),
    .Core_Done_i(core_done)
  );

  always #5 Clk_i = ~Clk_i;

  // Core model: mode 0 pulses done, mode 1 holds done until the next start, mode 2 never finishes.
  always @(posedge Clk_i) begin
    if (Core_Start_o) begin
      core_busy      <= 1'b1;
      core_cnt       <= 0;
      core_lat_angle <= Core_Angle_o;
      core_done      <= 1'b0;
    end else if (core_busy) begin
      if (core_cnt == CORE_LAT - 1) begin
        core_busy <= 1'b0;
        if (core_mode != 2) begin
          core_done <= 1'b1;
          core_sine <= ~core_lat_angle;
        end
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else if (core_mode != 1) begin
      core_done <= 1'b0;
    end
  end

  function automatic logic [ANGLE_W-1:0] ang_of(input int k);
    return 16'h0123 + 16'(k) * 16'h3000;
  endfunction

  task automatic set_angle(input int k, input logic [ANGLE_W-1:0] v);
    Angle_i[k*ANGLE_W +: ANGLE_W] = v;
  endtask

  task automatic pulse_reset();
    @(negedge Clk_i);
    Rst_i = 1'b1;
    @(negedge Clk_i);
    Rst_i = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk_i);
      cyc++;
    end while (Gnt_o == '0 && cyc < budget);
  endtask

  task automatic wait_valid(input int budget, output int cyc, output int starts);
    cyc    = 0;
    starts = 0;
    do begin
      @(negedge Clk_i);
      cyc++;
      if (Core_Start_o) starts++;
    end while (Valid_o == '0 && cyc < budget);
  endtask

  task automatic test_reset();
    @(negedge Clk_i);
    n_cmp++;
    if ({Gnt_o, Valid_o, Sine_o, Err_o, Busy_o, Core_Start_o, Core_Angle_o} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got %h want 0",
               {Gnt_o, Valid_o, Sine_o, Err_o, Busy_o, Core_Start_o, Core_Angle_o});
    end
    Rst_i = 1'b0;
    @(negedge Clk_i);
    n_cmp++;
    if (Busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_idle_busy: got %b want 0", Busy_o); end
    n_cmp++;
    if (Gnt_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_idle_gnt: got %b want 0000", Gnt_o); end
  endtask

  task automatic test_single();
    int vcyc, starts;
    set_angle(0, 16'd5461);
    Req_i = 4'b0001;
    @(negedge Clk_i);
    n_cmp++;
    if (Gnt_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_gnt: got %b want 0001", Gnt_o); end
    n_cmp++;
    if (Core_Start_o !== 1'b1) begin n_bad++; $display("[TB] FAIL single_start: got %b want 1", Core_Start_o); end
    n_cmp++;
    if (Core_Angle_o !== 16'd5461) begin n_bad++; $display("[TB] FAIL single_angle: got %0d want 5461", Core_Angle_o); end
    n_cmp++;
    if (Busy_o !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy: got %b want 1", Busy_o); end
    Req_i = 4'b0000;
    wait_valid(100, vcyc, starts);
    n_cmp++;
    if (vcyc !== CORE_LAT + 2) begin n_bad++; $display("[TB] FAIL single_latency: got %0d want %0d", vcyc, CORE_LAT + 2); end
    n_cmp++;
    if (starts !== 0) begin n_bad++; $display("[TB] FAIL single_start_pulse: extra starts %0d want 0", starts); end
    n_cmp++;
    if (Valid_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_valid: got %b want 0001", Valid_o); end
    n_cmp++;
    if (Sine_o !== 16'hEAAA) begin n_bad++; $display("[TB] FAIL single_sine: got %h want eaaa", Sine_o); end
    n_cmp++;
    if (Err_o !== 1'b0) begin n_bad++; $display("[TB] FAIL single_err: got %b want 0", Err_o); end
    @(negedge Clk_i);
    n_cmp++;
    if (Valid_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL single_valid_pulse: got %b want 0000", Valid_o); end
    @(negedge Clk_i);
    n_cmp++;
    if (Busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL single_idle: got busy %b want 0", Busy_o); end
  endtask

  task automatic test_contention();
    int gcyc, vcyc, starts, exp_id;
    vcyc = 0;
    pulse_reset();
    for (int k = 0; k < NUM_REQ; k++) set_angle(k, ang_of(k));
    Req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_id = n % NUM_REQ;
      wait_gnt(60, gcyc);
      n_cmp++;
      if (Gnt_o !== 4'(1 << exp_id)) begin n_bad++; $display("[TB] FAIL contention_gnt%0d: got %b want %b", n, Gnt_o, 4'(1 << exp_id)); end
      if (n > 0) begin
        n_cmp++;
        if (vcyc + gcyc !== CORE_LAT + 4) begin n_bad++; $display("[TB] FAIL back_to_back_spacing%0d: got %0d want %0d", n, vcyc + gcyc, CORE_LAT + 4); end
      end
      if (n == 4) Req_i = 4'b0000;
      wait_valid(100, vcyc, starts);
      n_cmp++;
      if (Valid_o !== 4'(1 << exp_id)) begin n_bad++; $display("[TB] FAIL contention_valid%0d: got %b want %b", n, Valid_o, 4'(1 << exp_id)); end
      n_cmp++;
      if (Sine_o !== ~ang_of(exp_id)) begin n_bad++; $display("[TB] FAIL contention_sine%0d: got %h want %h", n, Sine_o, ~ang_of(exp_id)); end
    end
    repeat (3) @(negedge Clk_i);
  endtask

  task automatic test_fairness();
    int gcyc, vcyc, starts, exp_id;
    pulse_reset();
    Req_i = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      exp_id = (n % 2 == 0) ? 0 : 2;
      wait_gnt(60, gcyc);
      n_cmp++;
      if (Gnt_o !== 4'(1 << exp_id)) begin n_bad++; $display("[TB] FAIL fairness_gnt%0d: got %b want %b", n, Gnt_o, 4'(1 << exp_id)); end
      if (n == 3) Req_i = 4'b0000;
      wait_valid(100, vcyc, starts);
      n_cmp++;
      if (Valid_o !== 4'(1 << exp_id)) begin n_bad++; $display("[TB] FAIL fairness_valid%0d: got %b want %b", n, Valid_o, 4'(1 << exp_id)); end
      n_cmp++;
      if (Sine_o !== ~ang_of(exp_id)) begin n_bad++; $display("[TB] FAIL fairness_sine%0d: got %h want %h", n, Sine_o, ~ang_of(exp_id)); end
    end
    repeat (3) @(negedge Clk_i);
  endtask

  task automatic test_held_done();
    int gcyc, vcyc, starts;
    core_mode = 1;
    set_angle(1, 16'h4000);
    Req_i = 4'b0010;
    wait_gnt(10, gcyc);
    n_cmp++;
    if (Gnt_o !== 4'b0010) begin n_bad++; $display("[TB] FAIL held_gnt1: got %b want 0010", Gnt_o); end
    Req_i = 4'b0000;
    set_angle(1, 16'h7777);
    wait_valid(100, vcyc, starts);
    n_cmp++;
    if (vcyc !== CORE_LAT + 2) begin n_bad++; $display("[TB] FAIL held_latency1: got %0d want %0d", vcyc, CORE_LAT + 2); end
    n_cmp++;
    if (Sine_o !== ~16'h4000) begin n_bad++; $display("[TB] FAIL held_sine1: got %h want %h", Sine_o, ~16'h4000); end
    repeat (4) @(negedge Clk_i);
    Req_i = 4'b0010;
    wait_gnt(10, gcyc);
    Req_i = 4'b0000;
    wait_valid(100, vcyc, starts);
    n_cmp++;
    if (vcyc !== CORE_LAT + 2) begin n_bad++; $display("[TB] FAIL held_latency2: got %0d want %0d", vcyc, CORE_LAT + 2); end
    n_cmp++;
    if (Valid_o !== 4'b0010) begin n_bad++; $display("[TB] FAIL held_valid2: got %b want 0010", Valid_o); end
    n_cmp++;
    if (Sine_o !== ~16'h7777) begin n_bad++; $display("[TB] FAIL held_sine2: got %h want %h", Sine_o, ~16'h7777); end
    repeat (3) @(negedge Clk_i);
  endtask

  task automatic test_watchdog();
    int gcyc, vcyc, starts;
    core_mode = 2;
    Req_i = 4'b1000;
    wait_gnt(10, gcyc);
    n_cmp++;
    if (Gnt_o !== 4'b1000) begin n_bad++; $display("[TB] FAIL watchdog_gnt: got %b want 1000", Gnt_o); end
    Req_i = 4'b0000;
    wait_valid(200, vcyc, starts);
    n_cmp++;
    if (vcyc !== TIMEOUT_CYC + 1) begin n_bad++; $display("[TB] FAIL watchdog_latency: got %0d want %0d", vcyc, TIMEOUT_CYC + 1); end
    n_cmp++;
    if (Valid_o !== 4'b1000) begin n_bad++; $display("[TB] FAIL watchdog_valid: got %b want 1000", Valid_o); end
    n_cmp++;
    if (Err_o !== 1'b1) begin n_bad++; $display("[TB] FAIL watchdog_err: got %b want 1", Err_o); end
    n_cmp++;
    if (Sine_o !== 16'h0000) begin n_bad++; $display("[TB] FAIL watchdog_sine: got %h want 0000", Sine_o); end
    repeat (2) @(negedge Clk_i);
    core_mode = 0;
    set_angle(2, 16'h2468);
    Req_i = 4'b0100;
    wait_gnt(10, gcyc);
    n_cmp++;
    if (Gnt_o !== 4'b0100) begin n_bad++; $display("[TB] FAIL watchdog_next_gnt: got %b want 0100", Gnt_o); end
    Req_i = 4'b0000;
    wait_valid(100, vcyc, starts);
    n_cmp++;
    if (vcyc !== CORE_LAT + 2) begin n_bad++; $display("[TB] FAIL watchdog_next_latency: got %0d want %0d", vcyc, CORE_LAT + 2); end
    n_cmp++;
    if (Err_o !== 1'b0) begin n_bad++; $display("[TB] FAIL watchdog_next_err: got %b want 0", Err_o); end
    n_cmp++;
    if (Sine_o !== ~16'h2468) begin n_bad++; $display("[TB] FAIL watchdog_next_sine: got %h want %h", Sine_o, ~16'h2468); end
    repeat (3) @(negedge Clk_i);
  endtask

  task automatic test_reset_in_wait();
    int gcyc, vcyc, starts, seen;
    Req_i = 4'b0010;
    wait_gnt(10, gcyc);
    Req_i = 4'b0000;
    repeat (5) @(negedge Clk_i);
    Rst_i = 1'b1;
    @(negedge Clk_i);
    n_cmp++;
    if ({Gnt_o, Valid_o, Sine_o, Err_o, Busy_o, Core_Start_o, Core_Angle_o} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_wait_outputs: got %h want 0",
               {Gnt_o, Valid_o, Sine_o, Err_o, Busy_o, Core_Start_o, Core_Angle_o});
    end
    Rst_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk_i);
      if (Valid_o != '0 || Busy_o) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("[TB] FAIL reset_wait_dropped: got %0d active cycles want 0", seen); end
    Req_i = 4'b1111;
    wait_gnt(10, gcyc);
    n_cmp++;
    if (Gnt_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL reset_wait_priority: got %b want 0001", Gnt_o); end
    Req_i = 4'b0000;
    wait_valid(100, vcyc, starts);
    n_cmp++;
    if (Valid_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL reset_wait_valid: got %b want 0001", Valid_o); end
    n_cmp++;
    if (Sine_o !== ~ang_of(0)) begin n_bad++; $display("[TB] FAIL reset_wait_sine: got %h want %h", Sine_o, ~ang_of(0)); end
  endtask

  initial begin
    Rst_i   = 1'b1;
    Req_i   = '0;
    Angle_i = '0;
    repeat (3) @(negedge Clk_i);
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_held_done();
    test_watchdog();
    test_reset_in_wait();
    repeat (3) @(negedge Clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
